data_mem_access: RTL

DATA_MEM_ACCESS -- requirements
Module: data_mem_access

---
 rtl/data_mem_access.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_access.sv
// Memory stage: issues one data-cache request per load or store and stalls the pipeline until
// the cache answers or the wait budget runs out. It also shapes results for the MEM/WB register.
module data_mem_access #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic [3:0]  mbe_in,
    input  logic [4:0]  rd_in,
    output logic        stall_out,
    output logic [31:0] d_addr,
    output logic        d_read,
    output logic        d_write,
    output logic [3:0]  d_mbe,
    output logic [31:0] d_wdata,
    input  logic [31:0] d_rdata,
    input  logic        d_resp,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_err,
    output logic        wb_misaligned
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    logic [31:0] d_addr_q, d_addr_d;
    logic        d_read_q, d_read_d;
    logic        d_write_q, d_write_d;
    logic [3:0]  d_mbe_q, d_mbe_d;
    logic [31:0] d_wdata_q, d_wdata_d;

    // Instruction context kept for the whole access so the result does not depend on upstream.
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic        store_q, store_d;

    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_err_q, wb_err_d;
    logic        wb_mis_q, wb_mis_d;

    logic        stall_c;
    logic        is_mem;
    logic        misaligned;
    logic [31:0] rdata_shift;
    logic [31:0] load_data;

    assign is_mem = mem_read_in | mem_write_in;

    // Width code bits [1:0] give the access size for both loads and stores.
    always_comb begin
        misaligned = 1'b0;
        case (funct3_in[1:0])
            2'b01:   misaligned = is_mem && (addr_in[1:0] == 2'b11);
            2'b10:   misaligned = is_mem && (addr_in[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    assign rdata_shift = d_rdata >> {off_q, 3'b000};

    always_comb begin
        load_data = d_rdata;
        case (f3_q)
            3'b000:  load_data = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  load_data = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b100:  load_data = {24'd0, rdata_shift[7:0]};
            3'b101:  load_data = {16'd0, rdata_shift[15:0]};
            default: load_data = d_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        d_addr_d   = d_addr_q;
        d_read_d   = d_read_q;
        d_write_d  = d_write_q;
        d_mbe_d    = d_mbe_q;
        d_wdata_d  = d_wdata_q;
        f3_d       = f3_q;
        off_d      = off_q;
        rd_d       = rd_q;
        store_d    = store_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_err_d   = wb_err_q;
        wb_mis_d   = wb_mis_q;
        stall_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (is_mem && !misaligned) begin
                        stall_c    = 1'b1;
                        state_d    = BUSY;
                        wait_cnt_d = '0;
                        d_addr_d   = {addr_in[31:2], 2'b00};
                        d_read_d   = mem_read_in;
                        d_write_d  = mem_write_in;
                        d_mbe_d    = mem_read_in ? 4'b1111 : mbe_in;
                        d_wdata_d  = mem_write_in ? (wdata_in << {addr_in[1:0], 3'b000}) : 32'd0;
                        f3_d       = funct3_in;
                        off_d      = addr_in[1:0];
                        rd_d       = rd_in;
                        store_d    = mem_write_in;
                    end else begin
                        // Pass-through results and suppressed misaligned accesses retire next edge.
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_in;
                        wb_err_d   = 1'b0;
                        wb_mis_d   = is_mem;
                        wb_data_d  = is_mem ? 32'd0 : addr_in;
                    end
                end
            end
            BUSY: begin
                if (d_resp) begin
                    state_d    = IDLE;
                    d_read_d   = 1'b0;
                    d_write_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = store_q ? 32'd0 : load_data;
                    wb_err_d   = 1'b0;
                    wb_mis_d   = 1'b0;
                end else if (wait_cnt_q == LAST_WAIT) begin
                    state_d    = IDLE;
                    d_read_d   = 1'b0;
                    d_write_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = 32'd0;
                    wb_err_d   = 1'b1;
                    wb_mis_d   = 1'b0;
                end else begin
                    stall_c    = 1'b1;
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            d_addr_q   <= '0;
            d_read_q   <= 1'b0;
            d_write_q  <= 1'b0;
            d_mbe_q    <= '0;
            d_wdata_q  <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            rd_q       <= '0;
            store_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_err_q   <= 1'b0;
            wb_mis_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            d_addr_q   <= d_addr_d;
            d_read_q   <= d_read_d;
            d_write_q  <= d_write_d;
            d_mbe_q    <= d_mbe_d;
            d_wdata_q  <= d_wdata_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
            store_q    <= store_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_err_q   <= wb_err_d;
            wb_mis_q   <= wb_mis_d;
        end
    end

    // Reset must also silence the combinational stall, since IDLE decode could otherwise raise it.
    assign stall_out     = rst & stall_c;
    assign d_addr        = d_addr_q;
    assign d_read        = d_read_q;
    assign d_write       = d_write_q;
    assign d_mbe         = d_mbe_q;
    assign d_wdata       = d_wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign wb_err        = wb_err_q;
    assign wb_misaligned = wb_mis_q;

endmodule
